// File: rtl/vreg_pkg.sv
// rtl/vreg_pkg.sv - configuration, widths and ROB entry type for the versioned register ROB
package vreg_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DATA_W    = 32;
    localparam int REGS      = 32;
    localparam int ROB_DEPTH = 16;
    localparam int RD_PORTS  = 4;
    localparam int WR_PORTS  = 2;
    localparam int COMMIT_W  = 2;
    localparam int ZERO_REG  = 1;

    localparam int AW = clog2(REGS);
    localparam int TW = clog2(ROB_DEPTH);
    localparam int CW = clog2(COMMIT_W + 1);

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dest;
        logic [AW-1:0]     dest;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/vreg_rob_if.sv
// rtl/vreg_rob_if.sv - dispatch, writeback, read, flush and commit signals of the ROB
interface vreg_rob_if;
    import vreg_pkg::*;

    logic                         alloc_valid;
    logic                         alloc_has_dest;
    logic [AW-1:0]                alloc_dest;
    logic                         alloc_ready;
    logic [TW-1:0]                alloc_tag;
    logic [WR_PORTS-1:0]          wb_valid;
    logic [WR_PORTS*TW-1:0]       wb_tag;
    logic [WR_PORTS*DATA_W-1:0]   wb_data;
    logic [RD_PORTS-1:0]          rd_use_tag;
    logic [RD_PORTS*TW-1:0]       rd_tag;
    logic [RD_PORTS*AW-1:0]       rd_addr;
    logic [RD_PORTS*DATA_W-1:0]   rd_data;
    logic [RD_PORTS-1:0]          rd_ready;
    logic                         flush;
    logic [COMMIT_W-1:0]          commit_valid;
    logic [COMMIT_W*TW-1:0]       commit_tag;
    logic [TW:0]                  rob_count;
    logic                         rob_empty;
    logic                         rob_full;

    modport master (
        output alloc_valid, alloc_has_dest, alloc_dest, wb_valid, wb_tag, wb_data,
               rd_use_tag, rd_tag, rd_addr, flush,
        input  alloc_ready, alloc_tag, rd_data, rd_ready, commit_valid, commit_tag,
               rob_count, rob_empty, rob_full
    );

    modport slave (
        input  alloc_valid, alloc_has_dest, alloc_dest, wb_valid, wb_tag, wb_data,
               rd_use_tag, rd_tag, rd_addr, flush,
        output alloc_ready, alloc_tag, rd_data, rd_ready, commit_valid, commit_tag,
               rob_count, rob_empty, rob_full
    );

endinterface

// File: rtl/vreg_rob_commit_sel.sv
// rtl/vreg_rob_commit_sel.sv - in-order retire selection over the oldest COMMIT_W entries
module vreg_commit_sel
    import vreg_pkg::*;
(
    input  logic [TW-1:0]        head,
    input  logic [ROB_DEPTH-1:0] valid_vec,
    input  logic [ROB_DEPTH-1:0] done_vec,
    input  logic [TW:0]          count,
    output logic [COMMIT_W-1:0]  mask,
    output logic [CW-1:0]        num
);

    // prefix-AND: a slot retires only if every older slot retires too
    always_comb begin
        logic          run;
        logic [TW-1:0] idx;
        run  = 1'b1;
        idx  = '0;
        mask = '0;
        num  = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            idx     = head + TW'(k);
            run     = run & valid_vec[idx] & done_vec[idx] & ((TW+1)'(k) < count);
            mask[k] = run;
            num     = num + CW'(run);
        end
    end

endmodule

// File: rtl/vreg_rob.sv
// rtl/vreg_rob.sv - circular ROB with architectural regfile, bypassed reads and in-order commit
module vreg_rob
    import vreg_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    vreg_rob_if.slave bus
);

    rob_entry_t                 rob   [ROB_DEPTH];
    rob_entry_t                 rob_n [ROB_DEPTH];
    logic [DATA_W-1:0]          rf    [REGS];
    logic [TW-1:0]              head;
    logic [TW-1:0]              tail;
    logic [TW:0]                count;
    logic [ROB_DEPTH-1:0]       valid_vec;
    logic [ROB_DEPTH-1:0]       done_vec;
    logic [COMMIT_W-1:0]        commit_mask;
    logic [CW-1:0]              commit_num;
    logic [TW-1:0]              head_next;
    logic                       full;
    logic                       alloc_fire;
    logic [RD_PORTS*DATA_W-1:0] rd_data_w;
    logic [RD_PORTS-1:0]        rd_ready_w;
    logic [COMMIT_W*TW-1:0]     commit_tag_w;

    assign full       = (count == (TW+1)'(ROB_DEPTH));
    assign alloc_fire = bus.alloc_valid & ~full & ~bus.flush;
    assign head_next  = head + TW'(commit_num);

    // flatten per-entry status for the retire selector
    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            valid_vec[i] = rob[i].valid;
            done_vec[i]  = rob[i].done;
        end
    end

    vreg_commit_sel u_commit_sel (
        .head      (head),
        .valid_vec (valid_vec),
        .done_vec  (done_vec),
        .count     (count),
        .mask      (commit_mask),
        .num       (commit_num)
    );

    // next ROB contents: retire, then flush or allocate and capture writebacks
    always_comb begin
        logic [TW-1:0] cidx;
        logic [TW-1:0] widx;
        cidx  = '0;
        widx  = '0;
        rob_n = rob;
        for (int k = 0; k < COMMIT_W; k++) begin
            cidx = head + TW'(k);
            if (commit_mask[k]) begin
                rob_n[cidx].valid = 1'b0;
                rob_n[cidx].done  = 1'b0;
            end
        end
        if (bus.flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_n[i].valid = 1'b0;
                rob_n[i].done  = 1'b0;
            end
        end else begin
            if (alloc_fire) begin
                rob_n[tail].valid    = 1'b1;
                rob_n[tail].done     = 1'b0;
                rob_n[tail].has_dest = bus.alloc_has_dest;
                rob_n[tail].dest     = bus.alloc_dest;
                rob_n[tail].data     = '0;
            end
            // ascending port order so the highest index wins on a shared tag
            for (int p = 0; p < WR_PORTS; p++) begin
                widx = bus.wb_tag[p*TW +: TW];
                if (bus.wb_valid[p] && rob[widx].valid && rob_n[widx].valid) begin
                    rob_n[widx].data = bus.wb_data[p*DATA_W +: DATA_W];
                    rob_n[widx].done = 1'b1;
                end
            end
        end
    end

    // ROB storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rob <= '{default: '0};
        else     rob <= rob_n;
    end

    // head/tail/count; flush rewinds tail to the post-commit head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head_next;
            if (bus.flush) begin
                tail  <= head_next;
                count <= '0;
            end else begin
                tail  <= tail + TW'(alloc_fire);
                count <= count + (TW+1)'(alloc_fire) - (TW+1)'(commit_num);
            end
        end
    end

    // regfile update from retiring entries; later slot (younger) overrides on same dest
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < REGS; j++) rf[j] <= DATA_W'(j);
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (commit_mask[k] && rob[head + TW'(k)].has_dest &&
                    !(ZERO_REG != 0 && rob[head + TW'(k)].dest == '0))
                    rf[rob[head + TW'(k)].dest] <= rob[head + TW'(k)].data;
            end
        end
    end

    // read ports: ROB by tag with writeback bypass, or regfile by address
    always_comb begin
        logic [TW-1:0] t;
        logic [AW-1:0] a;
        t          = '0;
        a          = '0;
        rd_data_w  = '0;
        rd_ready_w = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            t = bus.rd_tag[r*TW +: TW];
            a = bus.rd_addr[r*AW +: AW];
            if (bus.rd_use_tag[r]) begin
                if (rob[t].done) begin
                    rd_data_w[r*DATA_W +: DATA_W] = rob[t].data;
                    rd_ready_w[r]                 = 1'b1;
                end else begin
                    for (int p = 0; p < WR_PORTS; p++) begin
                        if (bus.wb_valid[p] && bus.wb_tag[p*TW +: TW] == t) begin
                            rd_data_w[r*DATA_W +: DATA_W] = bus.wb_data[p*DATA_W +: DATA_W];
                            rd_ready_w[r]                 = 1'b1;
                        end
                    end
                end
            end else begin
                rd_ready_w[r] = 1'b1;
                if (!(ZERO_REG != 0 && a == '0))
                    rd_data_w[r*DATA_W +: DATA_W] = rf[a];
            end
        end
    end

    // retiring tags are simply head+k
    always_comb begin
        commit_tag_w = '0;
        for (int k = 0; k < COMMIT_W; k++) commit_tag_w[k*TW +: TW] = head + TW'(k);
    end

    assign bus.alloc_ready  = ~full;
    assign bus.alloc_tag    = tail;
    assign bus.rd_data      = rd_data_w;
    assign bus.rd_ready     = rd_ready_w;
    assign bus.commit_valid = commit_mask;
    assign bus.commit_tag   = commit_tag_w;
    assign bus.rob_count    = count;
    assign bus.rob_empty    = (count == '0);
    assign bus.rob_full     = full;

endmodule

// File: tb/tb_vreg_rob.sv
// tb/tb_vreg_rob.sv - self-checking bench for vreg_rob against a queue-based ROB model
module tb_vreg_rob;
    import vreg_pkg::*;

    typedef struct {
        int                tag;
        bit                has_dest;
        int                dest;
        bit                done;
        logic [DATA_W-1:0] data;
    } m_ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    m_ent_t            mq[$];
    logic [DATA_W-1:0] mrf [REGS];
    int                mhead;
    int                mtail;

    always #5 clk = ~clk;

    vreg_rob_if bus();

    vreg_rob dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle_inputs();
        bus.alloc_valid    = 1'b0;
        bus.alloc_has_dest = 1'b0;
        bus.alloc_dest     = '0;
        bus.wb_valid       = '0;
        bus.wb_tag         = '0;
        bus.wb_data        = '0;
        bus.rd_use_tag     = '0;
        bus.rd_tag         = '0;
        bus.rd_addr        = '0;
        bus.flush          = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        mhead = 0;
        mtail = 0;
        for (int j = 0; j < REGS; j++) mrf[j] = DATA_W'(j);
    endtask

    function automatic int exp_ncommit();
        int n = 0;
        while (n < COMMIT_W && n < mq.size() && mq[n].done) n++;
        return n;
    endfunction

    task automatic exp_rd(input int r, output logic [DATA_W-1:0] d, output logic rdy);
        int t;
        int a;
        d   = '0;
        rdy = 1'b0;
        if (bus.rd_use_tag[r]) begin
            t = int'(bus.rd_tag[r*TW +: TW]);
            foreach (mq[i]) if (mq[i].tag == t && mq[i].done) begin d = mq[i].data; rdy = 1'b1; end
            if (!rdy)
                for (int p = 0; p < WR_PORTS; p++)
                    if (bus.wb_valid[p] && int'(bus.wb_tag[p*TW +: TW]) == t) begin
                        d   = bus.wb_data[p*DATA_W +: DATA_W];
                        rdy = 1'b1;
                    end
        end else begin
            a   = int'(bus.rd_addr[r*AW +: AW]);
            rdy = 1'b1;
            d   = (ZERO_REG != 0 && a == 0) ? '0 : mrf[a];
        end
    endtask

    task automatic model_step();
        int nc;
        int pre;
        pre = mq.size();
        nc  = exp_ncommit();
        for (int k = 0; k < nc; k++)
            if (mq[k].has_dest && !(ZERO_REG != 0 && mq[k].dest == 0)) mrf[mq[k].dest] = mq[k].data;
        for (int k = 0; k < nc; k++) void'(mq.pop_front());
        mhead = (mhead + nc) % ROB_DEPTH;
        if (bus.flush) begin
            mq.delete();
            mtail = mhead;
        end else begin
            for (int p = 0; p < WR_PORTS; p++)
                if (bus.wb_valid[p])
                    foreach (mq[i])
                        if (mq[i].tag == int'(bus.wb_tag[p*TW +: TW])) begin
                            mq[i].data = bus.wb_data[p*DATA_W +: DATA_W];
                            mq[i].done = 1'b1;
                        end
            if (bus.alloc_valid && pre < ROB_DEPTH) begin
                mq.push_back('{tag: mtail, has_dest: bus.alloc_has_dest,
                               dest: int'(bus.alloc_dest), done: 1'b0, data: '0});
                mtail = (mtail + 1) % ROB_DEPTH;
            end
        end
    endtask

    task automatic tick();
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rd_addr[0 +: AW] = AW'(9);
        #2;
        n_checks++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready got %0b want 1", bus.alloc_ready); end
        n_checks++; if (bus.alloc_tag !== 4'd0) begin n_fail++; $display("FAIL reset_alloc_tag got %0d want 0", bus.alloc_tag); end
        n_checks++; if (bus.rob_empty !== 1'b1 || bus.rob_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%0b full=%0b want 1/0", bus.rob_empty, bus.rob_full); end
        n_checks++; if (bus.rob_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.rob_count); end
        n_checks++; if (bus.commit_valid !== 2'b00) begin n_fail++; $display("FAIL reset_commit_valid got %b want 00", bus.commit_valid); end
        n_checks++; if (bus.rd_data[31:0] !== 32'd9 || bus.rd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reset_rf9 got %0h/%0b want 9/1", bus.rd_data[31:0], bus.rd_ready[0]); end
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < ROB_DEPTH; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(i + 1);
            #2;
            n_checks++; if (bus.alloc_tag !== TW'(i)) begin n_fail++; $display("FAIL fill_tag got %0d want %0d", bus.alloc_tag, i); end
            tick();
        end
        bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(17);
        #2;
        n_checks++; if (bus.rob_full !== 1'b1 || bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got full=%0b ready=%0b want 1/0", bus.rob_full, bus.alloc_ready); end
        n_checks++; if (bus.rob_count !== 5'd16) begin n_fail++; $display("FAIL fill_count got %0d want 16", bus.rob_count); end
        tick();
        #2;
        n_checks++; if (bus.alloc_tag !== 4'd0 || bus.rob_count !== 5'd16) begin n_fail++; $display("FAIL fill_17th got tag=%0d count=%0d want 0/16", bus.alloc_tag, bus.rob_count); end
        bus.flush = 1'b1;
        tick();
        #2;
        n_checks++; if (bus.rob_count !== 5'd0 || bus.alloc_tag !== 4'd0) begin n_fail++; $display("FAIL fill_flush got count=%0d tag=%0d want 0/0", bus.rob_count, bus.alloc_tag); end
    endtask

    task automatic test_same_dest();
        for (int i = 0; i < 2; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(5);
            #2;
            n_checks++; if (bus.alloc_tag !== TW'(i)) begin n_fail++; $display("FAIL same_dest_tag got %0d want %0d", bus.alloc_tag, i); end
            tick();
        end
        bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd1}; bus.wb_data = {32'h0, 32'hB};
        tick();
        bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd0}; bus.wb_data = {32'h0, 32'hA};
        #2;
        n_checks++; if (bus.commit_valid !== 2'b00) begin n_fail++; $display("FAIL same_dest_early got %b want 00", bus.commit_valid); end
        tick();
        #2;
        n_checks++; if (bus.commit_valid !== 2'b11 || bus.commit_tag !== 8'h10) begin n_fail++; $display("FAIL same_dest_commit got %b/%h want 11/10", bus.commit_valid, bus.commit_tag); end
        tick();
        bus.rd_addr[2*AW +: AW] = AW'(5);
        #2;
        n_checks++; if (bus.rd_data[64 +: 32] !== 32'hB || bus.rd_ready[2] !== 1'b1) begin n_fail++; $display("FAIL same_dest_rf5 got %0h want b", bus.rd_data[64 +: 32]); end
        tick();
    endtask

    task automatic test_bypass();
        bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(7);
        tick();
        bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(8);
        tick();
        bus.wb_valid = 2'b10; bus.wb_tag = {4'd3, 4'd0}; bus.wb_data = {32'h33, 32'h0};
        bus.rd_use_tag = 4'b0011; bus.rd_tag = 16'h0023;
        #2;
        n_checks++; if (bus.rd_data[31:0] !== 32'h33 || bus.rd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bypass_same_cycle got %0h/%0b want 33/1", bus.rd_data[31:0], bus.rd_ready[0]); end
        n_checks++; if (bus.rd_data[63:32] !== 32'h0 || bus.rd_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bypass_not_done got %0h/%0b want 0/0", bus.rd_data[63:32], bus.rd_ready[1]); end
        tick();
        bus.rd_use_tag = 4'b0001; bus.rd_tag = 16'h0003;
        #2;
        n_checks++; if (bus.rd_data[31:0] !== 32'h33 || bus.rd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bypass_from_rob got %0h/%0b want 33/1", bus.rd_data[31:0], bus.rd_ready[0]); end
        tick();
        bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd2}; bus.wb_data = {32'h0, 32'h22};
        tick();
        tick();
    endtask

    task automatic test_wrap();
        logic [3:0] want_tag [4];
        want_tag = '{4'd14, 4'd15, 4'd0, 4'd1};
        for (int i = 0; i < 10; i++) begin
            bus.alloc_valid = 1'b1;
            if (i > 0) begin bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, TW'(4 + i - 1)}; bus.wb_data = {32'h0, $urandom}; end
            tick();
        end
        bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd13}; bus.wb_data = {32'h0, 32'h13};
        tick();
        tick(); tick(); tick();
        #2;
        n_checks++; if (bus.rob_count !== 5'd0 || bus.alloc_tag !== 4'd14) begin n_fail++; $display("FAIL wrap_drain got count=%0d tag=%0d want 0/14", bus.rob_count, bus.alloc_tag); end
        for (int i = 0; i < 4; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(10 + i);
            #2;
            n_checks++; if (bus.alloc_tag !== want_tag[i]) begin n_fail++; $display("FAIL wrap_tag got %0d want %0d", bus.alloc_tag, want_tag[i]); end
            tick();
        end
        bus.wb_valid = 2'b11; bus.wb_tag = {4'd15, 4'd14}; bus.wb_data = {32'hF0, 32'hE0};
        tick();
        bus.wb_valid = 2'b11; bus.wb_tag = {4'd1, 4'd0}; bus.wb_data = {32'h101, 32'h100};
        #2;
        n_checks++; if (bus.commit_valid !== 2'b11 || bus.commit_tag !== 8'hFE) begin n_fail++; $display("FAIL wrap_commit_a got %b/%h want 11/fe", bus.commit_valid, bus.commit_tag); end
        tick();
        #2;
        n_checks++; if (bus.commit_valid !== 2'b11 || bus.commit_tag !== 8'h10) begin n_fail++; $display("FAIL wrap_commit_b got %b/%h want 11/10", bus.commit_valid, bus.commit_tag); end
        tick();
        bus.rd_addr[3*AW +: AW] = AW'(13);
        #2;
        n_checks++; if (bus.rob_count !== 5'd0 || bus.rob_empty !== 1'b1 || bus.alloc_tag !== 4'd2) begin n_fail++; $display("FAIL wrap_end got count=%0d empty=%0b tag=%0d want 0/1/2", bus.rob_count, bus.rob_empty, bus.alloc_tag); end
        n_checks++; if (bus.rd_data[96 +: 32] !== 32'h101) begin n_fail++; $display("FAIL wrap_rf13 got %0h want 101", bus.rd_data[96 +: 32]); end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(20 + i);
            tick();
        end
        bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd2}; bus.wb_data = {32'h0, 32'h77};
        tick();
        bus.flush = 1'b1; bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(30);
        bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd3}; bus.wb_data = {32'h0, 32'h99};
        #2;
        n_checks++; if (bus.commit_valid !== 2'b01 || bus.commit_tag[3:0] !== 4'd2) begin n_fail++; $display("FAIL flush_commit got %b/%0d want 01/2", bus.commit_valid, bus.commit_tag[3:0]); end
        tick();
        bus.rd_addr[0 +: AW] = AW'(20);
        #2;
        n_checks++; if (bus.rob_count !== 5'd0 || bus.rob_empty !== 1'b1 || bus.alloc_tag !== 4'd3) begin n_fail++; $display("FAIL flush_state got count=%0d empty=%0b tag=%0d want 0/1/3", bus.rob_count, bus.rob_empty, bus.alloc_tag); end
        n_checks++; if (bus.rd_data[31:0] !== 32'h77) begin n_fail++; $display("FAIL flush_rf20 got %0h want 77", bus.rd_data[31:0]); end
        tick();
    endtask

    task automatic test_zero_reg_and_rst();
        bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(0);
        tick();
        bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd3}; bus.wb_data = {32'h0, 32'h55};
        tick();
        #2;
        n_checks++; if (bus.commit_valid !== 2'b01) begin n_fail++; $display("FAIL zero_commit got %b want 01", bus.commit_valid); end
        tick();
        #2;
        n_checks++; if (bus.rd_data[31:0] !== 32'h0 || bus.rd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL zero_r0 got %0h/%0b want 0/1", bus.rd_data[31:0], bus.rd_ready[0]); end
        tick();
        bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(7);
        tick();
        bus.alloc_valid = 1'b1; bus.alloc_has_dest = 1'b1; bus.alloc_dest = AW'(8);
        bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd4}; bus.wb_data = {32'h0, 32'h44};
        tick();
        bus.alloc_valid = 1'b1; bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd5}; bus.wb_data = {32'h0, 32'h45};
        bus.rd_addr[0 +: AW] = AW'(5);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.rob_count !== 5'd0 || bus.rob_empty !== 1'b1 || bus.rob_full !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags got count=%0d empty=%0b full=%0b want 0/1/0", bus.rob_count, bus.rob_empty, bus.rob_full); end
        n_checks++; if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 4'd0 || bus.commit_valid !== 2'b00) begin n_fail++; $display("FAIL rst_mid_alloc got ready=%0b tag=%0d cv=%b want 1/0/00", bus.alloc_ready, bus.alloc_tag, bus.commit_valid); end
        n_checks++; if (bus.rd_data[31:0] !== 32'd5) begin n_fail++; $display("FAIL rst_mid_rf5 got %0h want 5", bus.rd_data[31:0]); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] ed;
        logic              er;
        logic [COMMIT_W-1:0] em;
        int nc;
        int phase;
        int pa;
        int pw;
        for (int i = 0; i < 600; i++) begin
            phase = (i / 40) % 3;
            pa = (phase == 0) ? 90 : (phase == 1) ? 15 : 50;
            pw = (phase == 0) ? 20 : (phase == 1) ? 90 : 50;
            bus.alloc_valid    = ($urandom_range(99) < pa);
            bus.alloc_has_dest = ($urandom_range(3) != 0);
            bus.alloc_dest     = AW'($urandom_range(REGS - 1));
            for (int p = 0; p < WR_PORTS; p++) begin
                bus.wb_valid[p] = ($urandom_range(99) < pw);
                if (mq.size() > 0 && $urandom_range(3) != 0)
                    bus.wb_tag[p*TW +: TW] = TW'(mq[$urandom_range(mq.size() - 1)].tag);
                else
                    bus.wb_tag[p*TW +: TW] = TW'($urandom_range(ROB_DEPTH - 1));
                bus.wb_data[p*DATA_W +: DATA_W] = $urandom;
            end
            if ($urandom_range(7) == 0) bus.wb_tag[TW +: TW] = bus.wb_tag[0 +: TW];
            for (int r = 0; r < RD_PORTS; r++) begin
                bus.rd_use_tag[r] = $urandom_range(1);
                if (mq.size() > 0 && $urandom_range(3) != 0)
                    bus.rd_tag[r*TW +: TW] = TW'(mq[$urandom_range(mq.size() - 1)].tag);
                else
                    bus.rd_tag[r*TW +: TW] = TW'($urandom_range(ROB_DEPTH - 1));
                bus.rd_addr[r*AW +: AW] = AW'($urandom_range(REGS - 1));
            end
            bus.flush = ($urandom_range(59) == 0);
            #2;
            n_checks++; if (bus.rob_count !== (TW+1)'(mq.size())) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d want %0d", i, bus.rob_count, mq.size()); end
            n_checks++; if (bus.alloc_ready !== (mq.size() < ROB_DEPTH) || bus.rob_full !== (mq.size() == ROB_DEPTH) || bus.rob_empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rand_flags cyc %0d got ready=%0b full=%0b empty=%0b size=%0d", i, bus.alloc_ready, bus.rob_full, bus.rob_empty, mq.size()); end
            n_checks++; if (bus.alloc_tag !== TW'(mtail)) begin n_fail++; $display("FAIL rand_alloc_tag cyc %0d got %0d want %0d", i, bus.alloc_tag, mtail); end
            nc = exp_ncommit();
            em = '0;
            for (int k = 0; k < nc; k++) em[k] = 1'b1;
            n_checks++; if (bus.commit_valid !== em) begin n_fail++; $display("FAIL rand_commit_valid cyc %0d got %b want %b", i, bus.commit_valid, em); end
            for (int k = 0; k < nc; k++) begin
                n_checks++; if (bus.commit_tag[k*TW +: TW] !== TW'(mq[k].tag)) begin n_fail++; $display("FAIL rand_commit_tag cyc %0d slot %0d got %0d want %0d", i, k, bus.commit_tag[k*TW +: TW], mq[k].tag); end
            end
            for (int r = 0; r < RD_PORTS; r++) begin
                exp_rd(r, ed, er);
                n_checks++; if (bus.rd_data[r*DATA_W +: DATA_W] !== ed || bus.rd_ready[r] !== er) begin n_fail++; $display("FAIL rand_read cyc %0d port %0d got %0h/%0b want %0h/%0b", i, r, bus.rd_data[r*DATA_W +: DATA_W], bus.rd_ready[r], ed, er); end
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_fill();
        test_same_dest();
        test_bypass();
        test_wrap();
        test_flush();
        test_zero_reg_and_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
